// File: rtl/encounter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : encounter_pkg
//  Description : Shared types for the encounter spawner: spawn type codes
//                and the spawn handshake state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package encounter_pkg;

    // Spawn type carried through the FIFO and out to the renderer.
    typedef logic [1:0] enc_type_t;

    localparam enc_type_t ENC_NONE = 2'd0;
    localparam enc_type_t ENC_1    = 2'd1;
    localparam enc_type_t ENC_2    = 2'd2;
    localparam enc_type_t ENC_3    = 2'd3;

    // Spawn handshake state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/enc_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : enc_fifo
//  Description : Small synchronous FIFO for spawn events. A push is accepted
//                when not full, or when a pop happens on the same edge. A
//                flush empties the FIFO on the next edge.
//  Ports       : clock, reset      - clock and synchronous active-high reset
//                flush             - empty the FIFO (synchronous)
//                push, push_data   - write request and data
//                pop               - read request (ignored when empty)
//                pop_data          - head entry (valid while not empty)
//                full, empty, count- occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem_q [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr_q, r_wr_ptr_d;
    logic [PTR_W-1:0] r_rd_ptr_q, r_rd_ptr_d;
    logic [PTR_W:0]   r_count_q,  r_count_d;

    logic w_do_push;
    logic w_do_pop;

    assign full     = (r_count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (r_count_q == '0);
    assign count    = r_count_q;
    assign pop_data = r_mem_q[r_rd_ptr_q];

    // A full FIFO may still take a push when the head leaves on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_comb begin
        r_wr_ptr_d = r_wr_ptr_q;
        r_rd_ptr_d = r_rd_ptr_q;
        r_count_d  = r_count_q;
        if (flush) begin
            r_wr_ptr_d = '0;
            r_rd_ptr_d = '0;
            r_count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_do_push) r_wr_ptr_d = r_wr_ptr_q + 1'b1;
            if (w_do_pop)  r_rd_ptr_d = r_rd_ptr_q + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count_d = r_count_q + 1'b1;
                2'b01:   r_count_d = r_count_q - 1'b1;
                default: r_count_d = r_count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
        end else begin
            r_wr_ptr_q <= r_wr_ptr_d;
            r_rd_ptr_q <= r_rd_ptr_d;
            r_count_q  <= r_count_d;
        end
    end

    // Storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge clock) begin
        if (w_do_push && !flush && !reset) begin
            r_mem_q[r_wr_ptr_q] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/encounter_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : encounter_spawner
//  Description : Turns rising edges of the three encounter-select levels into
//                typed spawn events, queues them, and offers them to the
//                obstacle renderer over valid/ready with a minimum gap
//                between accepted spawns.
//  Ports       : clock, reset             - clock, synchronous active-high reset
//                enc1_in..enc3_in         - encounter select levels
//                game_active              - run in progress; low flushes
//                spawn_ready              - renderer accepts the offer
//                spawn_valid, spawn_type  - offered spawn event
//                fifo_count               - queued events behind the offer
//                drop_count               - saturating count of lost events
//                busy                     - offering or cooling down
//  Revision    : 1.0 - initial release
// ============================================================================
module encounter_spawner
    import encounter_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 50000000,
    parameter int GAP_W   = 26,
    parameter int DROP_W  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enc1_in,
    input  logic                   enc2_in,
    input  logic                   enc3_in,
    input  logic                   game_active,
    input  logic                   spawn_ready,
    output logic                   spawn_valid,
    output logic [1:0]             spawn_type,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   busy
);

    localparam int        SUM_W     = DROP_W + 2;
    localparam [GAP_W-1:0] C_GAP_LOAD = GAP_W'(MIN_GAP - 1);

    // Edge detect
    logic [2:0]  r_prev_q, r_prev_d;
    logic [2:0]  w_rise;
    logic [1:0]  w_rise_cnt;
    logic        w_event;
    enc_type_t   w_event_type;

    // FIFO interface
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_overflow;
    enc_type_t   w_head;

    // Drop counter
    logic [1:0]        w_drop_inc;
    logic [SUM_W-1:0]  w_drop_sum;
    logic [DROP_W-1:0] r_drop_q, r_drop_d;

    // Handshake FSM
    state_t      r_state_q, r_state_d;
    logic [GAP_W-1:0] r_gap_q, r_gap_d;
    logic        r_valid_q, r_valid_d;
    enc_type_t   r_type_q,  r_type_d;
    logic        r_busy_q,  r_busy_d;

    // Rises are still tracked while inactive so a level held across a
    // flush does not produce a late event once the run resumes.
    assign r_prev_d   = {enc3_in, enc2_in, enc1_in};
    assign w_rise     = game_active ? (r_prev_d & ~r_prev_q) : 3'b000;
    assign w_rise_cnt = 2'(w_rise[0]) + 2'(w_rise[1]) + 2'(w_rise[2]);
    assign w_event    = |w_rise;

    always_comb begin
        if (w_rise[0])      w_event_type = ENC_1;
        else if (w_rise[1]) w_event_type = ENC_2;
        else                w_event_type = ENC_3;
    end

    assign w_pop      = (r_state_q == IDLE) & game_active & ~w_empty;
    assign w_push     = w_event & (~w_full | w_pop);
    assign w_overflow = w_event & w_full & ~w_pop;

    // Losers of the same-cycle arbitration plus an overflowed winner.
    assign w_drop_inc = w_event ? ((w_rise_cnt - 2'd1) + 2'(w_overflow)) : 2'd0;
    assign w_drop_sum = SUM_W'(r_drop_q) + SUM_W'(w_drop_inc);

    always_comb begin
        if (w_drop_sum[SUM_W-1:DROP_W] != '0) r_drop_d = '1;
        else                                   r_drop_d = w_drop_sum[DROP_W-1:0];
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (~game_active),
        .push      (w_push),
        .push_data (w_event_type),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (fifo_count)
    );

    always_comb begin
        r_state_d = r_state_q;
        r_gap_d   = r_gap_q;
        r_valid_d = r_valid_q;
        r_type_d  = r_type_q;
        if (!game_active) begin
            // Flush: any pending offer is discarded silently.
            r_state_d = IDLE;
            r_gap_d   = '0;
            r_valid_d = 1'b0;
            r_type_d  = ENC_NONE;
        end else begin
            case (r_state_q)
                IDLE: begin
                    if (w_pop) begin
                        r_state_d = OFFER;
                        r_valid_d = 1'b1;
                        r_type_d  = w_head;
                    end
                end
                OFFER: begin
                    if (spawn_ready) begin
                        r_state_d = COOLDOWN;
                        r_gap_d   = C_GAP_LOAD;
                        r_valid_d = 1'b0;
                        r_type_d  = ENC_NONE;
                    end
                end
                COOLDOWN: begin
                    // MIN_GAP cooldown cycles, then one IDLE cycle before
                    // the next pop.
                    if (r_gap_q == '0) r_state_d = IDLE;
                    else               r_gap_d   = r_gap_q - 1'b1;
                end
                default: begin
                    r_state_d = IDLE;
                    r_gap_d   = '0;
                    r_valid_d = 1'b0;
                    r_type_d  = ENC_NONE;
                end
            endcase
        end
        r_busy_d = (r_state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prev_q  <= '0;
            r_drop_q  <= '0;
            r_state_q <= IDLE;
            r_gap_q   <= '0;
            r_valid_q <= 1'b0;
            r_type_q  <= ENC_NONE;
            r_busy_q  <= 1'b0;
        end else begin
            r_prev_q  <= r_prev_d;
            r_drop_q  <= r_drop_d;
            r_state_q <= r_state_d;
            r_gap_q   <= r_gap_d;
            r_valid_q <= r_valid_d;
            r_type_q  <= r_type_d;
            r_busy_q  <= r_busy_d;
        end
    end

    assign spawn_valid = r_valid_q;
    assign spawn_type  = r_type_q;
    assign drop_count  = r_drop_q;
    assign busy        = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_encounter_spawner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encounter_spawner
//  Description : Self-checking bench for encounter_spawner (DEPTH=4,
//                MIN_GAP=4). A time-based reference model tracks the event
//                queue, the current offer and the earliest cycle at which a
//                new spawn may be offered; outputs are compared each cycle,
//                and directed scenarios add hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_encounter_spawner;

    localparam int DEPTH   = 4;
    localparam int MIN_GAP = 4;
    localparam int GAP_W   = 26;
    localparam int DROP_W  = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enc1_in = 1'b0, enc2_in = 1'b0, enc3_in = 1'b0;
    logic       game_active = 1'b0;
    logic       spawn_ready = 1'b0;
    logic       spawn_valid;
    logic [1:0] spawn_type;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [DROP_W-1:0]      drop_count;
    logic       busy;

    int errors = 0;
    int checks = 0;

    encounter_spawner #(
        .DEPTH   (DEPTH),
        .MIN_GAP (MIN_GAP),
        .GAP_W   (GAP_W),
        .DROP_W  (DROP_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enc1_in     (enc1_in),
        .enc2_in     (enc2_in),
        .enc3_in     (enc3_in),
        .game_active (game_active),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .fifo_count  (fifo_count),
        .drop_count  (drop_count),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model. An accepted spawn at edge A forbids any new offer
    // until edge A+MIN_GAP+1; busy covers the offer and the MIN_GAP
    // cycles that follow an acceptance.
    // ------------------------------------------------------------------
    int       m_q[$];
    bit [2:0] m_prev, m_in, m_rises;
    bit       m_offer, m_accept, m_pop, m_full, m_started;
    int       m_type, m_cool_until, m_drop, m_edge, m_nrise, m_lost;

    initial begin
        m_edge = 0; m_started = 0; m_offer = 0; m_type = 0;
        m_cool_until = 0; m_drop = 0; m_prev = 0;
    end

    always @(posedge clock) begin
        m_edge++;
        if (reset) begin
            m_q.delete();
            m_prev       = 3'b000;
            m_offer      = 0;
            m_type       = 0;
            m_cool_until = m_edge;
            m_drop       = 0;
            m_started    = 1;
        end else begin
            m_in    = {enc3_in, enc2_in, enc1_in};
            m_rises = m_in & ~m_prev;
            m_prev  = m_in;
            if (!game_active) begin
                m_q.delete();
                m_offer      = 0;
                m_cool_until = m_edge;
            end else begin
                m_accept = m_offer && spawn_ready;
                m_pop    = !m_offer && (m_edge > m_cool_until) && (m_q.size() > 0);
                m_full   = (m_q.size() == DEPTH);
                m_nrise  = int'(m_rises[0]) + int'(m_rises[1]) + int'(m_rises[2]);
                m_lost   = 0;
                if (m_pop) begin
                    m_type  = m_q.pop_front();
                    m_offer = 1;
                end
                if (m_nrise > 0) begin
                    m_lost = m_nrise - 1;
                    if (m_full && !m_pop) m_lost++;
                    else m_q.push_back(m_rises[0] ? 1 : (m_rises[1] ? 2 : 3));
                end
                if (m_accept) begin
                    m_offer      = 0;
                    m_cool_until = m_edge + MIN_GAP;
                end
                m_drop = (m_drop + m_lost > 255) ? 255 : m_drop + m_lost;
            end
        end
    end

    always @(negedge clock) begin
        if (m_started) begin
            check("cyc_valid", spawn_valid, m_offer ? 1 : 0);
            check("cyc_type",  spawn_type,  m_offer ? m_type : 0);
            check("cyc_fifo",  fifo_count,  m_q.size());
            check("cyc_drop",  drop_count,  m_drop);
            check("cyc_busy",  busy, (m_offer || (m_edge < m_cool_until)) ? 1 : 0);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change just after a falling edge.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_enc(input int k, input logic v);
        if (k == 1) enc1_in = v;
        else if (k == 2) enc2_in = v;
        else enc3_in = v;
    endtask

    task automatic pulse(input int k);
        set_enc(k, 1'b1);
        tick(1);
        set_enc(k, 1'b0);
        tick(1);
    endtask

    int seen[$];
    int gaps[$];
    int low;
    bit got;

    initial begin
        // Reset state
        reset = 1'b1;
        tick(3);
        check("rst_valid", spawn_valid, 0);
        check("rst_type",  spawn_type,  0);
        check("rst_fifo",  fifo_count,  0);
        check("rst_drop",  drop_count,  0);
        check("rst_busy",  busy,        0);

        // Single event: two-clock latency, one-cycle offer with ready high
        reset = 1'b0; game_active = 1'b1; spawn_ready = 1'b1;
        tick(2);
        enc2_in = 1'b1;
        tick(1);
        check("single_fifo_push", fifo_count, 1);
        check("single_not_yet",   spawn_valid, 0);
        tick(1);
        check("single_valid", spawn_valid, 1);
        check("single_type",  spawn_type,  2);
        enc2_in = 1'b0;
        tick(1);
        check("single_accepted", spawn_valid, 0);
        check("single_busy",     busy, 1);
        tick(10);

        // Backpressure then ordered release with enforced gaps
        spawn_ready = 1'b0;
        pulse(1); pulse(3); pulse(2);
        check("bp_valid", spawn_valid, 1);
        check("bp_type",  spawn_type,  1);
        check("bp_fifo",  fifo_count,  2);
        tick(3);
        check("bp_type_held", spawn_type, 1);
        spawn_ready = 1'b1;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            if (spawn_valid) begin
                if (low > 0) gaps.push_back(low);
                seen.push_back(int'(spawn_type));
                low = 0;
            end else begin
                low++;
            end
            tick(1);
        end
        check("bp_count",  seen.size(), 3);
        check("bp_order0", (seen.size() > 0) ? seen[0] : -1, 1);
        check("bp_order1", (seen.size() > 1) ? seen[1] : -1, 3);
        check("bp_order2", (seen.size() > 2) ? seen[2] : -1, 2);
        check("bp_gap0",   (gaps.size() > 0) ? gaps[0] : -1, MIN_GAP + 1);
        check("bp_gap1",   (gaps.size() > 1) ? gaps[1] : -1, MIN_GAP + 1);

        // Simultaneous rises: enc1 wins, enc3 counted as dropped
        enc1_in = 1'b1; enc3_in = 1'b1;
        tick(1);
        check("simul_drop", drop_count, 1);
        check("simul_fifo", fifo_count, 1);
        enc1_in = 1'b0; enc3_in = 1'b0;
        tick(1);
        check("simul_type", spawn_type, 1);
        tick(10);

        // Overflow and saturation
        reset = 1'b1;
        tick(1);
        reset = 1'b0; spawn_ready = 1'b0;
        for (int i = 0; i < 6; i++) pulse(2);
        check("ovf_valid", spawn_valid, 1);
        check("ovf_fifo",  fifo_count,  4);
        check("ovf_drop",  drop_count,  1);
        for (int i = 0; i < 260; i++) pulse((i % 3) + 1);
        check("ovf_sat", drop_count, 255);

        // Flush with a pending offer; rise during the flush is lost
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        pulse(1); pulse(2); pulse(3); pulse(1);
        check("fl_pre_valid", spawn_valid, 1);
        check("fl_pre_fifo",  fifo_count,  3);
        game_active = 1'b0; enc3_in = 1'b1;
        tick(1);
        check("fl_valid", spawn_valid, 0);
        check("fl_fifo",  fifo_count,  0);
        check("fl_drop",  drop_count,  0);
        game_active = 1'b1;
        tick(12);
        check("fl_no_spawn", spawn_valid, 0);
        enc3_in = 1'b0;
        tick(1);

        // Reset during cooldown, inputs high across release
        spawn_ready = 1'b1;
        pulse(2);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            if (spawn_valid) got = 1;
            else tick(1);
        end
        check("rc_offer_seen", got, 1);
        tick(2);
        check("rc_busy", busy, 1);
        reset = 1'b1; enc1_in = 1'b1; enc2_in = 1'b1; enc3_in = 1'b1;
        tick(1);
        check("rc_valid", spawn_valid, 0);
        check("rc_busy0", busy, 0);
        check("rc_drop0", drop_count, 0);
        reset = 1'b0;
        tick(1);
        check("rc_not_yet", spawn_valid, 0);
        tick(1);
        check("rc_valid1", spawn_valid, 1);
        check("rc_type1",  spawn_type,  1);
        check("rc_drop2",  drop_count,  2);
        enc1_in = 1'b0; enc2_in = 1'b0; enc3_in = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/encounter_spawner.md
Name: encounter_spawner

Overview:
Consumes the three encounter-select levels from the random encounter generator. Converts their rising edges into typed spawn events and buffers the events in a small FIFO. Events go to the obstacle/render stage through a valid/ready handshake, with an enforced minimum gap between spawns. Sits between the encounter generator and the game's obstacle renderer.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
MIN_GAP, 50000000, cooldown clocks after each accepted spawn (1 s at 50 MHz); at least 1.
GAP_W, 26, cooldown counter width; must hold MIN_GAP-1.
DROP_W, 8, width of the saturating drop counter.

Ports:
clock  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
enc1_in  in  1  encounter 1 select level
enc2_in  in  1  encounter 2 select level
enc3_in  in  1  encounter 3 select level
game_active  in  1  high while a run is in progress; low flushes the block
spawn_ready  in  1  downstream accepts the offered spawn
spawn_valid  out  1  spawn event offered
spawn_type  out  2  1=enc1, 2=enc2, 3=enc3; 0 when spawn_valid is low
fifo_count  out  clog2(DEPTH)+1  queued events, excluding the one being offered
drop_count  out  DROP_W  events lost; saturating
busy  out  1  high in OFFER or COOLDOWN

Behaviour:
- Reset, synchronous: edge registers=0, FIFO empty, state=IDLE, gap=0, spawn_valid=0, spawn_type=0, fifo_count=0, drop_count=0, busy=0.
- Edge detect: one prev register per input. rise_k = enc_k_in & ~prev_k. Prev registers update every cycle, including while game_active=0.
  - An input already high when reset releases produces an event on the first cycle.
- Event select: only one push per cycle, with priority enc1 > enc2 > enc3.
  - Each additional simultaneous rise increments drop_count.
  - Pushes happen only when game_active=1.
- FIFO push/pop:
  - Push when an event exists and (not full, or a pop occurs in the same cycle). Full with no pop: event dropped, drop_count += 1.
  - drop_count saturates at all-ones and is cleared only by reset.
  - Push and pop in the same cycle: count unchanged. Empty FIFO with push and no pop: plain push; no bypass.
- FSM:
  - IDLE: if FIFO non-empty and game_active, pop the head into the spawn_type register, go to OFFER.
  - OFFER: spawn_valid=1 and spawn_type held stable until the handshake. On spawn_valid & spawn_ready: gap loads MIN_GAP-1, spawn_type goes to 0, go to COOLDOWN.
  - COOLDOWN: if gap=0 go to IDLE, else decrement gap.
  - The spawn_valid low time between accepted spawns is exactly MIN_GAP+1 cycles: MIN_GAP cooldown cycles plus one IDLE cycle.
- Latency: input rises before edge N → pushed at N → IDLE pops at N+1 → spawn_valid high after edge N+1, i.e. 2 clocks, when idle and empty.
- game_active=0, synchronous flush on the same edge:
  - FIFO emptied, state=IDLE, gap=0, spawn_valid=0, spawn_type=0.
  - An offered, unaccepted spawn is discarded and not counted as dropped.
  - No event while game_active=0 is ever queued, including a rise in the same cycle.
- Reset mid-operation wins over everything and returns all state to reset values on that edge.

Decomposition:
- Package encounter_pkg:
  - type codes ENC_NONE=0, ENC_1=1, ENC_2=2, ENC_3=3
  - 2-bit enc_type_t
  - FSM state encoding: IDLE, OFFER, COOLDOWN
- Sub-module enc_fifo: synchronous FIFO with DEPTH/WIDTH=2, push/pop/full/empty/count, same-cycle push+pop allowed when full.
- Edge detect, arbitration, FSM and counters stay in encounter_spawner.

Test Plan (bench uses MIN_GAP=4, DEPTH=4):
- Single event: reset, game_active=1, spawn_ready=1; raise enc2_in at edge 10 → spawn_valid=1, spawn_type=2 after edge 11; one cycle later spawn_valid=0; next spawn_valid no earlier than 5 cycles of low time.
- Backpressure: spawn_ready=0; pulse enc1, enc3, enc2 rises on separate cycles → spawn_type=1 held stable, fifo_count=2. Release spawn_ready → types 1, 3, 2 in order, with 5 low cycles between valids.
- Simultaneous rises: enc1_in and enc3_in rise on the same edge → one event of type 1; drop_count=1.
- Overflow: spawn_ready=0; 6 separate rises → 1 offered, fifo_count=4, drop_count=1. Then 260 more rises → drop_count=255 (saturated).
- Flush: with a spawn offered and fifo_count=3, drop game_active for 1 cycle → spawn_valid=0, fifo_count=0 next cycle, drop_count unchanged. A rise during game_active=0 is never spawned.
- Reset mid-cooldown: assert reset 2 cycles after a handshake → all outputs 0 next edge; inputs high at release → spawn of type 1 two clocks after release.
